// File: rtl/state_monitor_multi.sv
// Multi-channel input monitor: each channel's stable state follows its raw input only after the
// change has persisted for delay_sel*SCALE cycles; reports pulses, sticky flags and counters.
module state_monitor_multi #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DLY_W = 4,
    parameter int unsigned SCALE = 10000,
    parameter int unsigned CNT_W = 18
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ena,
    input  logic [WIDTH-1:0] i_in_raw,
    input  logic [DLY_W-1:0] i_delay_sel,
    input  logic             i_bypass,
    input  logic [WIDTH-1:0] i_flag_clr,
    input  logic             i_cnt_clr,
    output logic [WIDTH-1:0] o_stable,
    output logic [WIDTH-1:0] o_chg_pulse,
    output logic [WIDTH-1:0] o_chg_sticky,
    output logic [WIDTH-1:0] o_settling,
    output logic [7:0]       o_event_count,
    output logic [7:0]       o_glitch_count
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SETTLE = 1'b1;
    localparam int unsigned PW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_in_q;
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_chg_pulse;
    logic [WIDTH-1:0] r_chg_sticky;
    logic [WIDTH-1:0] r_state;
    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic [7:0]       r_event_count;
    logic [7:0]       r_glitch_count;

    logic [WIDTH-1:0] w_state_d;
    logic [WIDTH-1:0] w_stable_d;
    logic [WIDTH-1:0] w_accept;
    logic [WIDTH-1:0] w_glitch;
    logic [CNT_W-1:0] w_cnt_d [WIDTH];
    logic [CNT_W-1:0] w_load;

    function automatic logic [PW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [PW-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + PW'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] c, input logic [PW-1:0] p);
        logic [PW+8:0] s;
        s = (PW + 9)'(c) + (PW + 9)'(p);
        return (s > (PW + 9)'(255)) ? 8'hFF : s[7:0];
    endfunction

    assign w_load = CNT_W'(i_delay_sel) * CNT_W'(SCALE);

    always_comb begin
        w_state_d  = r_state;
        w_stable_d = r_stable;
        w_cnt_d    = r_cnt;
        w_accept   = '0;
        w_glitch   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_bypass) begin
                w_state_d[i]  = ST_IDLE;
                w_stable_d[i] = r_in_q[i];
                w_accept[i]   = r_in_q[i] ^ r_stable[i];
            end else if (r_state[i] == ST_IDLE) begin
                if (r_in_q[i] != r_stable[i]) begin
                    w_state_d[i] = ST_SETTLE;
                    w_cnt_d[i]   = w_load;
                end
            end else if (r_in_q[i] == r_stable[i]) begin
                // Input returned to the stable value before the settle time expired
                w_glitch[i]  = 1'b1;
                w_state_d[i] = ST_IDLE;
            end else if (r_cnt[i] == '0) begin
                w_accept[i]   = 1'b1;
                w_stable_d[i] = r_in_q[i];
                w_state_d[i]  = ST_IDLE;
            end else begin
                w_cnt_d[i] = r_cnt[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_in_q         <= '0;
            r_stable       <= '0;
            r_chg_pulse    <= '0;
            r_chg_sticky   <= '0;
            r_state        <= '0;
            r_event_count  <= '0;
            r_glitch_count <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_in_q <= i_in_raw;
            if (i_ena) begin
                r_state      <= w_state_d;
                r_cnt        <= w_cnt_d;
                r_stable     <= w_stable_d;
                r_chg_pulse  <= w_accept;
                r_chg_sticky <= (r_chg_sticky & ~i_flag_clr) | w_accept;
                if (i_cnt_clr) begin
                    r_event_count  <= '0;
                    r_glitch_count <= '0;
                end else begin
                    r_event_count  <= sat_add(r_event_count, popcount(w_accept));
                    r_glitch_count <= sat_add(r_glitch_count, popcount(w_glitch));
                end
            end else begin
                r_chg_pulse <= '0;
            end
        end
    end

    assign o_stable       = r_stable;
    assign o_chg_pulse    = r_chg_pulse;
    assign o_chg_sticky   = r_chg_sticky;
    assign o_settling     = r_state;
    assign o_event_count  = r_event_count;
    assign o_glitch_count = r_glitch_count;

endmodule

// File: tb/tb_state_monitor_multi.sv
// Bench for state_monitor_multi: directed scenarios with literal expectations plus random
// stimulus, all outputs compared every cycle against a deadline-based behavioural model.
module tb_state_monitor_multi;

    localparam int unsigned SCALE = 4;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] in_raw;
    logic [3:0] delay_sel;
    logic       bypass;
    logic [7:0] flag_clr;
    logic       cnt_clr;
    logic [7:0] o_stable;
    logic [7:0] o_chg_pulse;
    logic [7:0] o_chg_sticky;
    logic [7:0] o_settling;
    logic [7:0] o_event_count;
    logic [7:0] o_glitch_count;

    state_monitor_multi #(
        .WIDTH(8),
        .DLY_W(4),
        .SCALE(SCALE),
        .CNT_W(18)
    ) u_dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_ena         (ena),
        .i_in_raw      (in_raw),
        .i_delay_sel   (delay_sel),
        .i_bypass      (bypass),
        .i_flag_clr    (flag_clr),
        .i_cnt_clr     (cnt_clr),
        .o_stable      (o_stable),
        .o_chg_pulse   (o_chg_pulse),
        .o_chg_sticky  (o_chg_sticky),
        .o_settling    (o_settling),
        .o_event_count (o_event_count),
        .o_glitch_count(o_glitch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cycle    = 0;

    // Model: a settle started in enabled cycle s with length n accepts in enabled cycle s+n+1
    // if the input never matched the stable value in between.
    logic [7:0] m_inq, m_stable, m_pulse, m_sticky, m_busy;
    int         m_start [8];
    int         m_n     [8];
    int         m_ev, m_gl, m_cyc;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h (cycle %0d)", name, act, exp, cycle);
    endtask

    task automatic model_step();
        logic [7:0] acc, glt, d;
        if (!rst_n) begin
            m_inq = 0; m_stable = 0; m_pulse = 0; m_sticky = 0; m_busy = 0;
            m_ev = 0; m_gl = 0;
            return;
        end
        if (!ena) begin
            m_pulse = 0;
            m_inq   = in_raw;
            return;
        end
        acc = 0;
        glt = 0;
        d   = m_inq ^ m_stable;
        for (int i = 0; i < 8; i++) begin
            if (bypass) begin
                m_busy[i] = 1'b0;
                acc[i]    = d[i];
            end else if (!m_busy[i]) begin
                if (d[i]) begin
                    m_busy[i]  = 1'b1;
                    m_start[i] = m_cyc;
                    m_n[i]     = int'(delay_sel) * SCALE;
                end
            end else if (!d[i]) begin
                glt[i]    = 1'b1;
                m_busy[i] = 1'b0;
            end else if (m_cyc - m_start[i] == m_n[i] + 1) begin
                acc[i]    = 1'b1;
                m_busy[i] = 1'b0;
            end
        end
        m_stable = m_stable ^ acc;
        m_pulse  = acc;
        m_sticky = (m_sticky & ~flag_clr) | acc;
        if (cnt_clr) begin
            m_ev = 0;
            m_gl = 0;
        end else begin
            m_ev = (m_ev + $countones(acc) > 255) ? 255 : m_ev + $countones(acc);
            m_gl = (m_gl + $countones(glt) > 255) ? 255 : m_gl + $countones(glt);
        end
        m_inq = in_raw;
        m_cyc++;
    endtask

    task automatic compare();
        chk("stable", o_stable, m_stable);
        chk("chg_pulse", o_chg_pulse, m_pulse);
        chk("chg_sticky", o_chg_sticky, m_sticky);
        chk("settling", o_settling, m_busy);
        chk("event_count", o_event_count, 8'(m_ev));
        chk("glitch_count", o_glitch_count, 8'(m_gl));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cycle++;
        compare();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        logic [7:0] mask;
        m_cyc = 0;
        rst_n = 0; ena = 1; in_raw = 8'hFF; delay_sel = 4'd2;
        bypass = 0; flag_clr = 0; cnt_clr = 0;

        // Reset with all inputs high, then release: N = 8, update at t+10
        tick();
        chk("rst_stable", o_stable, 8'h00);
        tick();
        chk("rst_event", o_event_count, 8'h00);
        rst_n = 1;
        tick();
        tick();
        chk("rel_settling", o_settling, 8'hFF);
        ticks(8);
        chk("rel_stable_t9", o_stable, 8'h00);
        tick();
        chk("rel_stable_t10", o_stable, 8'hFF);
        chk("rel_pulse", o_chg_pulse, 8'hFF);
        chk("rel_sticky", o_chg_sticky, 8'hFF);
        chk("rel_event", o_event_count, 8'd8);
        tick();
        chk("rel_pulse_end", o_chg_pulse, 8'h00);

        delay_sel = 4'd0; in_raw = 8'h00;
        ticks(4);
        chk("clr_all_event", o_event_count, 8'd16);

        // Glitch: 5-cycle pulse on ch2 with N = 12
        delay_sel = 4'd3; in_raw = 8'h04;
        ticks(3);
        chk("glitch_settling", o_settling, 8'h04);
        ticks(2);
        in_raw = 8'h00;
        ticks(3);
        chk("glitch_count", o_glitch_count, 8'd1);
        chk("glitch_stable", o_stable, 8'h00);
        chk("glitch_event", o_event_count, 8'd16);

        // Zero delay: update at t+2
        delay_sel = 4'd0; in_raw = 8'h01;
        ticks(2);
        chk("d0_stable_t1", o_stable, 8'h00);
        tick();
        chk("d0_stable_t2", o_stable, 8'h01);
        chk("d0_pulse", o_chg_pulse, 8'h01);
        chk("d0_event", o_event_count, 8'd17);

        // delay_sel change mid-settle is ignored
        delay_sel = 4'd1; in_raw = 8'h03;
        ticks(2);
        delay_sel = 4'd15;
        ticks(4);
        chk("mid_stable_t5", o_stable, 8'h01);
        tick();
        chk("mid_stable_t6", o_stable, 8'h03);
        chk("mid_event", o_event_count, 8'd18);

        // Saturation: 38 toggles of all channels = 304 events
        delay_sel = 4'd0;
        for (int k = 0; k < 38; k++) begin
            in_raw = ~in_raw;
            ticks(3);
        end
        chk("sat_event", o_event_count, 8'd255);
        flag_clr = 8'hFF;
        tick();
        flag_clr = 8'h00;
        chk("flag_clr_all", o_chg_sticky, 8'h00);
        in_raw = 8'h01;
        ticks(2);
        cnt_clr = 1; flag_clr = 8'h02;
        tick();
        chk("cnt_clr_event", o_event_count, 8'd0);
        chk("cnt_clr_glitch", o_glitch_count, 8'd0);
        chk("set_wins_sticky", o_chg_sticky, 8'h02);
        cnt_clr = 0;
        tick();
        flag_clr = 8'h00;
        chk("flag_clr_ch1", o_chg_sticky, 8'h00);

        // Bypass then freeze
        in_raw = 8'h00;
        ticks(4);
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        chk("pre_bypass_event", o_event_count, 8'd0);
        bypass = 1; in_raw = 8'hA5;
        tick();
        chk("byp_stable_t0", o_stable, 8'h00);
        tick();
        chk("byp_stable_t1", o_stable, 8'hA5);
        chk("byp_pulse", o_chg_pulse, 8'hA5);
        chk("byp_event", o_event_count, 8'd4);
        ena = 0; in_raw = 8'h5A;
        tick();
        chk("ena0_pulse", o_chg_pulse, 8'h00);
        in_raw = 8'hFF;
        tick();
        in_raw = 8'h00;
        tick();
        chk("ena0_stable", o_stable, 8'hA5);
        chk("ena0_sticky", o_chg_sticky, 8'hA5);
        chk("ena0_event", o_event_count, 8'd4);
        ena = 1; bypass = 0;

        // Random phase
        for (int k = 0; k < 3000; k++) begin
            for (int b = 0; b < 8; b++) mask[b] = ($urandom_range(0, 9) == 0);
            in_raw    = in_raw ^ mask;
            delay_sel = 4'($urandom_range(0, 2));
            bypass    = ($urandom_range(0, 49) == 0);
            ena       = ($urandom_range(0, 19) != 0);
            flag_clr  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00;
            cnt_clr   = ($urandom_range(0, 199) == 0);
            rst_n     = ($urandom_range(0, 499) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
